// File: rtl/rgb2gray_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2gray_frame_ctrl
//  Function : Frame sequencer feeding a float RGB-to-gray converter from three
//             sync-read planes and writing results in order, with a stallable
//             valid pipeline.
//  Revision : 1.0
// ============================================================================
module rgb2gray_frame_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int CONV_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] frame_len,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] r_in,
   input  logic [DATA_W-1:0] g_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              conv_en,
   output logic [DATA_W-1:0] r,
   output logic [DATA_W-1:0] g,
   output logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] gray,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready
);

   localparam int              c_lat  = MEM_LAT + 1 + CONV_LAT;
   localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [c_lat-1:0]   r_vld;
   logic [ADDR_W-1:0]  r_last;
   logic               w_wr_acc;

   // A write that the output plane refuses freezes the whole pipeline,
   // including the external planes and converter.
   assign wr_en    = r_vld[c_lat-1];
   assign wr_data  = gray;
   assign conv_en  = !(wr_en && !wr_ready);
   assign rd_en    = (r_state == S_RUN) && conv_en;
   assign w_wr_acc = wr_en && wr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_addr <= '0;
         wr_addr <= '0;
         r_last  <= '0;
      end else if (abort) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_wr_acc) begin
            wr_addr <= wr_addr + c_one;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  rd_addr <= '0;
                  wr_addr <= '0;
                  r_last  <= frame_len - c_one;
                  if (frame_len != '0) begin
                     r_state <= S_RUN;
                     busy    <= 1'b1;
                  end else begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (rd_en) begin
                  // Address parks on the last pixel so it never wraps.
                  if (rd_addr == r_last) begin
                     r_state <= S_DRAIN;
                  end else begin
                     rd_addr <= rd_addr + c_one;
                  end
               end
            end
            S_DRAIN: begin
               if (r_vld == '0) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else if (abort) begin
         r_vld <= '0;
      end else if (conv_en) begin
         r_vld <= {r_vld[c_lat-2:0], rd_en};
      end
   end

   // Stage MEM_LAT-1 marks the cycle in which plane data is on r_in/g_in/b_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else if (conv_en && r_vld[MEM_LAT-1]) begin
         r <= r_in;
         g <= g_in;
         b <= b_in;
      end
   end

endmodule
`default_nettype wire
